ensemble_vote_ctrl: RTL

Frame-level controller for the three-classifier ensemble (gradient boost = 0, logistic regression = 1, MLP = 2). Accepts one feature frame on a single AXI-Stream slave and broadcasts every beat to all three classifier input streams with an eager fork. It then collects one prediction per classifier, with a timeout, and emits a single majority-vote result beat. Sits between the DMA feature stream and the classifier wrapper; the wrapper's per-classifier streams connect directly to the `c*` ports.

---
 rtl/ensemble_vote_ctrl_if.sv | 15 +
 rtl/ensemble_vote_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ensemble_vote_ctrl_if.sv
// AXI-Stream bundle shared by the feature, broadcast, result and vote streams
// of the ensemble vote controller.
interface ensemble_vote_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ensemble_vote_ctrl.sv
// Frame controller for the three-classifier ensemble: eager-fork broadcast of one
// feature frame, per-classifier result capture with timeout, and a majority vote beat.
module ensemble_vote_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int KEEP_WIDTH     = 4,
    parameter int CLASS_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ensemble_vote_ctrl_if.slave  s_axis,
    ensemble_vote_ctrl_if.master m_axis_c0,
    ensemble_vote_ctrl_if.master m_axis_c1,
    ensemble_vote_ctrl_if.master m_axis_c2,
    ensemble_vote_ctrl_if.slave  s_axis_c0,
    ensemble_vote_ctrl_if.slave  s_axis_c1,
    ensemble_vote_ctrl_if.slave  s_axis_c2,
    ensemble_vote_ctrl_if.master m_axis,
    output logic                 busy,
    output logic [15:0]          frame_count,
    output logic [15:0]          timeout_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_FEED, ST_WAIT, ST_VOTE, ST_OUT} state_t;

    state_t                          state_q, state_d;
    logic [2:0]                      sent_q, sent_d;
    logic [2:0]                      got_q, got_d;
    logic [2:0][CLASS_WIDTH-1:0]     res_q, res_d;
    logic [TW-1:0]                   timer_q, timer_d;
    logic                            to_flag_q, to_flag_d;
    logic [DATA_WIDTH-1:0]           out_data_q, out_data_d;
    logic                            out_valid_q, out_valid_d;
    logic [15:0]                     frame_count_q, frame_count_d;
    logic [15:0]                     timeout_count_q, timeout_count_d;

    logic                            feed, capture, up_hs;
    logic [2:0]                      c_ready, c_valid;
    logic [2:0]                      r_valid, r_last, r_ready, r_cap, got_new;
    logic [2:0][CLASS_WIDTH-1:0]     r_data;
    logic                            unused_bits;

    logic                            eq01, eq02, eq12;
    logic [CLASS_WIDTH-1:0]          vote_class;
    logic [1:0]                      vote_agree;
    logic [2:0]                      vote_mask;
    logic [DATA_WIDTH-1:0]           vote_word;

    assign feed    = (state_q == ST_FEED);
    assign capture = feed | (state_q == ST_WAIT);

    // Eager fork: a branch that already took the current beat drops its valid
    // until the upstream beat is finally consumed by the slowest branch.
    assign c_ready = {m_axis_c2.tready, m_axis_c1.tready, m_axis_c0.tready};
    assign c_valid = {3{feed & s_axis.tvalid}} & ~sent_q;
    assign s_axis.tready = feed & (&(sent_q | c_ready));
    assign up_hs = s_axis.tvalid & s_axis.tready;

    assign m_axis_c0.tvalid = c_valid[0];
    assign m_axis_c1.tvalid = c_valid[1];
    assign m_axis_c2.tvalid = c_valid[2];
    assign m_axis_c0.tdata  = s_axis.tdata;
    assign m_axis_c1.tdata  = s_axis.tdata;
    assign m_axis_c2.tdata  = s_axis.tdata;
    assign m_axis_c0.tkeep  = s_axis.tkeep;
    assign m_axis_c1.tkeep  = s_axis.tkeep;
    assign m_axis_c2.tkeep  = s_axis.tkeep;
    assign m_axis_c0.tlast  = s_axis.tlast;
    assign m_axis_c1.tlast  = s_axis.tlast;
    assign m_axis_c2.tlast  = s_axis.tlast;

    assign r_valid = {s_axis_c2.tvalid, s_axis_c1.tvalid, s_axis_c0.tvalid};
    assign r_last  = {s_axis_c2.tlast, s_axis_c1.tlast, s_axis_c0.tlast};
    assign r_data  = {s_axis_c2.tdata[CLASS_WIDTH-1:0], s_axis_c1.tdata[CLASS_WIDTH-1:0],
                      s_axis_c0.tdata[CLASS_WIDTH-1:0]};
    assign r_ready = {3{capture}} & ~got_q;
    assign r_cap   = r_ready & r_valid & r_last;
    assign got_new = got_q | r_cap;

    assign s_axis_c0.tready = r_ready[0];
    assign s_axis_c1.tready = r_ready[1];
    assign s_axis_c2.tready = r_ready[2];

    assign unused_bits = ^{s_axis_c0.tdata[DATA_WIDTH-1:CLASS_WIDTH], s_axis_c1.tdata[DATA_WIDTH-1:CLASS_WIDTH],
                           s_axis_c2.tdata[DATA_WIDTH-1:CLASS_WIDTH], s_axis_c0.tkeep, s_axis_c1.tkeep,
                           s_axis_c2.tkeep};

    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tdata  = out_data_q;
    assign m_axis.tkeep  = {KEEP_WIDTH{1'b1}};
    assign m_axis.tlast  = 1'b1;

    assign busy          = (state_q != ST_FEED) | (|sent_q);
    assign frame_count   = frame_count_q;
    assign timeout_count = timeout_count_q;

    // Majority vote over captured results; ties between distinct classes fall
    // back to classifier priority 2 > 1 > 0.
    always_comb begin
        eq01       = got_q[0] & got_q[1] & (res_q[0] == res_q[1]);
        eq02       = got_q[0] & got_q[2] & (res_q[0] == res_q[2]);
        eq12       = got_q[1] & got_q[2] & (res_q[1] == res_q[2]);
        vote_class = '0;
        vote_agree = 2'd0;
        if (eq01 && eq02) begin
            vote_class = res_q[0];
            vote_agree = 2'd3;
        end else if (eq01 || eq02) begin
            vote_class = res_q[0];
            vote_agree = 2'd2;
        end else if (eq12) begin
            vote_class = res_q[1];
            vote_agree = 2'd2;
        end else if (got_q[2]) begin
            vote_class = res_q[2];
            vote_agree = 2'd1;
        end else if (got_q[1]) begin
            vote_class = res_q[1];
            vote_agree = 2'd1;
        end else if (got_q[0]) begin
            vote_class = res_q[0];
            vote_agree = 2'd1;
        end
        for (int k = 0; k < 3; k++) begin
            vote_mask[k] = got_q[k] & (res_q[k] == vote_class);
        end
        vote_word                                = '0;
        vote_word[CLASS_WIDTH-1:0]               = vote_class;
        vote_word[CLASS_WIDTH+1:CLASS_WIDTH]     = vote_agree;
        vote_word[CLASS_WIDTH+4:CLASS_WIDTH+2]   = vote_mask;
        vote_word[CLASS_WIDTH+5]                 = to_flag_q;
    end

    always_comb begin
        state_d         = state_q;
        sent_d          = sent_q;
        got_d           = got_new;
        res_d           = res_q;
        timer_d         = timer_q;
        to_flag_d       = to_flag_q;
        out_data_d      = out_data_q;
        out_valid_d     = out_valid_q;
        frame_count_d   = frame_count_q;
        timeout_count_d = timeout_count_q;
        for (int k = 0; k < 3; k++) begin
            if (r_cap[k]) res_d[k] = r_data[k];
        end
        case (state_q)
            ST_FEED: begin
                sent_d = up_hs ? 3'b000 : (sent_q | (c_valid & c_ready));
                if (up_hs && s_axis.tlast) begin
                    state_d = ST_WAIT;
                    timer_d = '0;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + 1'b1;
                // A result landing on the expiry cycle still wins over the timeout.
                if (&got_new) begin
                    state_d   = ST_VOTE;
                    to_flag_d = 1'b0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d   = ST_VOTE;
                    to_flag_d = 1'b1;
                end
            end
            ST_VOTE: begin
                out_data_d  = vote_word;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (m_axis.tready) begin
                    out_valid_d   = 1'b0;
                    out_data_d    = '0;
                    got_d         = 3'b000;
                    sent_d        = 3'b000;
                    to_flag_d     = 1'b0;
                    frame_count_d = frame_count_q + 16'd1;
                    if (to_flag_q) timeout_count_d = timeout_count_q + 16'd1;
                    state_d       = ST_FEED;
                end
            end
            default: state_d = ST_FEED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_FEED;
            sent_q          <= '0;
            got_q           <= '0;
            res_q           <= '0;
            timer_q         <= '0;
            to_flag_q       <= 1'b0;
            out_data_q      <= '0;
            out_valid_q     <= 1'b0;
            frame_count_q   <= '0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            sent_q          <= sent_d;
            got_q           <= got_d;
            res_q           <= res_d;
            timer_q         <= timer_d;
            to_flag_q       <= to_flag_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
            frame_count_q   <= frame_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end
endmodule
